mac_beat_issuer: RTL and testbench



---
 rtl/mac_beat_issuer.sv | 170 +++++++++++++++++
 tb/tb_mac_beat_issuer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_beat_issuer.sv
// Producer side of the per-neuron ack/ack_mac handshake: accumulates x*w beats,
// pulses ack per beat and presents the saturated sum once the counter confirms.
module mac_beat_issuer #(
  parameter int N_INPUTS = 3,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int FRAC     = 8,
  parameter int TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ack,
  output logic                     cnt_rst,
  input  logic                     ack_mac,
  output logic signed [DATA_W-1:0] result,
  output logic                     result_valid,
  input  logic                     res_ready,
  output logic                     err,
  output logic                     busy
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam int BW = $clog2(N_INPUTS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BLAST = BW'(N_INPUTS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic signed [SW-1:0] AMAX =
    {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] AMIN = ~AMAX;
  localparam logic signed [ACC_W-1:0] DMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DMIN = ~DMAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [BW-1:0]      beat_q, beat_d;
  logic        [TW-1:0]      timer_q, timer_d;
  logic                      ack_q, ack_d;
  logic                      cnt_rst_q, cnt_rst_d;
  logic signed [DATA_W-1:0]  result_q, result_d;
  logic                      rv_q, rv_d;
  logic                      err_q, err_d;

  logic signed [PW-1:0]      x_ext, w_ext, prod, prod_sh;
  logic signed [SW-1:0]      p_ext, a_ext, sum;
  logic signed [ACC_W-1:0]   acc_sat;
  logic signed [DATA_W-1:0]  res_sat;
  logic                      accept;

  assign x_ext   = {{DATA_W{x_data[DATA_W-1]}}, x_data};
  assign w_ext   = {{DATA_W{w_data[DATA_W-1]}}, w_data};
  assign prod    = x_ext * w_ext;
  assign prod_sh = prod >>> FRAC;
  assign p_ext   = {{(SW-PW){prod_sh[PW-1]}}, prod_sh};
  assign a_ext   = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign sum     = p_ext + a_ext;

  always_comb begin
    acc_sat = sum[ACC_W-1:0];
    if (sum > AMAX) acc_sat = AMAX[ACC_W-1:0];
    else if (sum < AMIN) acc_sat = AMIN[ACC_W-1:0];
  end

  always_comb begin
    res_sat = acc_q[DATA_W-1:0];
    if (acc_q > DMAX) res_sat = DMAX[DATA_W-1:0];
    else if (acc_q < DMIN) res_sat = DMIN[DATA_W-1:0];
  end

  assign in_ready = (state_q == ISSUE);
  assign accept   = in_ready & in_valid;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    timer_d   = timer_q;
    ack_d     = 1'b0;
    cnt_rst_d = 1'b0;
    result_d  = result_q;
    rv_d      = rv_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          acc_d     = '0;
          beat_d    = '0;
          cnt_rst_d = 1'b1;
        end
      end
      ISSUE: begin
        // Counter still holds last job's sticky ack_mac until our clear lands.
        if (ack_mac && !cnt_rst_q) err_d = 1'b1;
        if (accept) begin
          acc_d  = acc_sat;
          ack_d  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == BLAST) begin
            state_d = WAIT;
            timer_d = '0;
          end
        end
      end
      WAIT: begin
        if (ack_mac || timer_q == TLAST) begin
          if (!ack_mac) err_d = 1'b1;
          state_d  = DONE;
          result_d = res_sat;
          rv_d     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      cnt_rst_q <= 1'b0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      beat_q    <= beat_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      cnt_rst_q <= cnt_rst_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      err_q     <= err_d;
    end
  end

  assign ack          = ack_q;
  assign cnt_rst      = cnt_rst_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mac_beat_issuer.sv
// Bench for mac_beat_issuer: integer reference model plus beat-counter
// environment, per-cycle output compare and hand-computed job results.
module tb_mac_beat_issuer;

  localparam int N = 3;
  localparam int TO = 15;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_data = '0;
  logic [15:0] w_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ack;
  logic        cnt_rst;
  logic        ack_mac;
  logic [15:0] result;
  logic        result_valid;
  logic        res_ready = 1'b0;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  mac_beat_issuer dut (
    .clk(clk), .rst(rst), .start(start),
    .x_data(x_data), .w_data(w_data), .in_valid(in_valid),
    .in_ready(in_ready), .ack(ack), .cnt_rst(cnt_rst),
    .ack_mac(ack_mac), .result(result), .result_valid(result_valid),
    .res_ready(res_ready), .err(err), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream beat counter environment, with fault overrides.
  int   cnt = 0;
  logic am_r = 1'b0;
  logic force_hi = 1'b0;
  logic force_lo = 1'b0;
  always @(negedge clk) begin
    if (rst || cnt_rst) begin
      cnt  <= 0;
      am_r <= 1'b0;
    end else if (ack) begin
      cnt <= cnt + 1;
      if (cnt + 1 >= N) am_r <= 1'b1;
    end
  end
  assign ack_mac = force_hi | (am_r & ~force_lo);

  // Reference model in plain integer arithmetic.
  function automatic longint clampl(longint v, longint lo, longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  int          cyc = 0;
  int          m_phase = 0;
  longint      m_acc = 0;
  int          m_beats = 0;
  int          m_wait = 0;
  bit          m_ack = 0;
  bit          m_crst = 0;
  logic [15:0] m_result = '0;
  bit          m_rv = 0;
  bit          m_err = 0;
  int          m_acc_cyc = 0;

  always @(negedge clk) begin
    bit nack, ncr;
    longint p;
    cyc++;
    nack = 0;
    ncr  = 0;
    if (rst) begin
      m_phase = 0; m_acc = 0; m_beats = 0; m_wait = 0;
      m_result = '0; m_rv = 0; m_err = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_acc = 0; m_beats = 0; ncr = 1;
        end
        1: begin
          if (ack_mac && !m_crst) m_err = 1;
          if (in_valid) begin
            p = longint'($signed(x_data)) * longint'($signed(w_data));
            m_acc = clampl(m_acc + (p >>> 8), -(64'sd1 <<< 31),
                           (64'sd1 <<< 31) - 1);
            nack = 1;
            m_beats++;
            if (m_beats == N) begin
              m_phase = 2; m_wait = 0; m_acc_cyc = cyc;
            end
          end
        end
        2: begin
          if (ack_mac || m_wait == TO - 1) begin
            if (!ack_mac) m_err = 1;
            m_result = 16'(clampl(m_acc, -32768, 32767));
            m_rv = 1;
            m_phase = 3;
          end else m_wait++;
        end
        default: if (res_ready) begin
          m_rv = 0; m_phase = 0;
        end
      endcase
    end
    m_ack  = nack;
    m_crst = ncr;
  end

  // Per-cycle compare on the opposite edge, plus job monitors.
  bit          chk_en = 0;
  bit          prev_rv = 0;
  int          n_ack = 0;
  int          n_crst = 0;
  int          rise_cyc = 0;
  logic [15:0] cap_result = '0;

  always @(posedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_phase == 1);
      chk("busy", busy, m_phase != 0);
      chk("ack", ack, m_ack);
      chk("cnt_rst", cnt_rst, m_crst);
      chk("result_valid", result_valid, m_rv);
      chk("result", result, m_result);
      chk("err", err, m_err);
      if (ack) n_ack++;
      if (cnt_rst) n_crst++;
      if (result_valid && !prev_rv) begin
        rise_cyc   = cyc;
        cap_result = result;
      end
      prev_rv = result_valid;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic run_job(input string nm,
                         input logic [15:0] xs [3], input logic [15:0] ws [3],
                         input int gap, input int hold, input bit sd,
                         input int fmode, input logic [15:0] exp_r,
                         input bit exp_err, input int exp_lat);
    int k;
    n_ack = 0;
    n_crst = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    force_hi = (fmode == 1);
    force_lo = (fmode == 2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      x_data = xs[i];
      w_data = ws[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    k = 0;
    while (!result_valid && k < 40) begin
      tick();
      k++;
    end
    if (!result_valid) chk({nm, "_rv_timeout"}, 0, 1);
    force_hi = 1'b0;
    force_lo = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = sd && (h == 1);
      tick();
    end
    res_ready = 1'b1;
    start = sd;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    tick();
    tick();
    chk({nm, "_result"}, cap_result, exp_r);
    chk({nm, "_acks"}, n_ack, 3);
    chk({nm, "_cnt_rst"}, n_crst, 1);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_idle"}, busy, 0);
    if (exp_lat >= 0) chk({nm, "_latency"}, rise_cyc - m_acc_cyc, exp_lat);
  endtask

  initial begin
    repeat (3) tick();
    chk_en = 1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ack", ack, 0);
    rst = 1'b0;
    tick();

    run_job("nominal", '{16'h0100, 16'h0100, 16'h0100},
            '{16'h0100, 16'h0100, 16'h0100}, 0, 0, 0, 0, 16'h0300, 0, 2);
    run_job("mixed", '{16'h0200, 16'hFF00, 16'h0080},
            '{16'h0100, 16'h0300, 16'hFE00}, 0, 1, 0, 0, 16'hFE00, 0, 2);
    run_job("sat_pos", '{16'h7FFF, 16'h7FFF, 16'h7FFF},
            '{16'h7FFF, 16'h7FFF, 16'h7FFF}, 0, 0, 0, 0, 16'h7FFF, 0, 2);
    run_job("sat_neg", '{16'h8000, 16'h8000, 16'h8000},
            '{16'h7FFF, 16'h7FFF, 16'h7FFF}, 0, 0, 0, 0, 16'h8000, 0, 2);
    run_job("backpres", '{16'h0100, 16'h0200, 16'h0300},
            '{16'h0040, 16'h0040, 16'h0040}, 4, 5, 1, 0, 16'h0180, 0, 2);

    // Abort mid-ISSUE after one large beat; no carry-over into next job.
    start = 1'b1;
    tick();
    start = 1'b0;
    x_data = 16'h7FFF;
    w_data = 16'h7FFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_cnt_rst", cnt_rst, 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_result", result, 0);
    rst = 1'b0;
    tick();
    run_job("post_rst", '{16'h0100, 16'h0100, 16'h0100},
            '{16'h0200, 16'h0100, 16'hFF00}, 0, 0, 0, 0, 16'h0200, 0, 2);

    run_job("early_am", '{16'h0100, 16'h0100, 16'h0100},
            '{16'h0100, 16'h0100, 16'h0100}, 0, 0, 0, 1, 16'h0300, 1, -1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_job("timeout", '{16'h0100, 16'h0100, 16'h0100},
            '{16'h0010, 16'h0020, 16'h0030}, 0, 0, 0, 2, 16'h0060, 1, 15);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
